// File: rtl/cgra_im_loader_if.sv
// DTL loader port bundle between the host (master) and the instruction-memory loader (slave).
interface cgra_im_loader_if #(
  parameter int INTERFACE_WIDTH       = 32,
  parameter int INTERFACE_ADDR_WIDTH  = 32,
  parameter int INTERFACE_BLOCK_WIDTH = 5
);
  logic                             iDTL_Loader_CommandValid;
  logic                             oDTL_Loader_CommandAccept;
  logic                             iDTL_Loader_CommandReadWrite;
  logic [INTERFACE_ADDR_WIDTH-1:0]  iDTL_Loader_Address;
  logic [INTERFACE_BLOCK_WIDTH-1:0] iDTL_Loader_BlockSize;
  logic                             iDTL_Loader_WriteValid;
  logic                             oDTL_Loader_WriteAccept;
  logic [INTERFACE_WIDTH/8-1:0]     iDTL_Loader_WriteEnable;
  logic [INTERFACE_WIDTH-1:0]       iDTL_Loader_WriteData;
  logic                             iDTL_Loader_WriteLast;
  logic                             oDTL_Loader_ReadValid;
  logic                             iDTL_Loader_ReadAccept;
  logic                             oDTL_Loader_ReadLast;
  logic [INTERFACE_WIDTH-1:0]       oDTL_Loader_ReadData;

  modport slave (
    input  iDTL_Loader_CommandValid, iDTL_Loader_CommandReadWrite, iDTL_Loader_Address,
           iDTL_Loader_BlockSize, iDTL_Loader_WriteValid, iDTL_Loader_WriteEnable,
           iDTL_Loader_WriteData, iDTL_Loader_WriteLast, iDTL_Loader_ReadAccept,
    output oDTL_Loader_CommandAccept, oDTL_Loader_WriteAccept, oDTL_Loader_ReadValid,
           oDTL_Loader_ReadLast, oDTL_Loader_ReadData
  );

  modport master (
    output iDTL_Loader_CommandValid, iDTL_Loader_CommandReadWrite, iDTL_Loader_Address,
           iDTL_Loader_BlockSize, iDTL_Loader_WriteValid, iDTL_Loader_WriteEnable,
           iDTL_Loader_WriteData, iDTL_Loader_WriteLast, iDTL_Loader_ReadAccept,
    input  oDTL_Loader_CommandAccept, oDTL_Loader_WriteAccept, oDTL_Loader_ReadValid,
           oDTL_Loader_ReadLast, oDTL_Loader_ReadData
  );
endinterface

// File: rtl/cgra_im_loader.sv
// DTL slave turning host write bursts into one-cycle instruction-memory write strobes (1 cycle after the beat).
// Accepts are registered from the next state; the host throttles reads via ReadAccept.
module cgra_im_loader #(
  parameter int INTERFACE_WIDTH       = 32,
  parameter int INTERFACE_ADDR_WIDTH  = 32,
  parameter int INTERFACE_BLOCK_WIDTH = 5,
  parameter int I_WIDTH               = 12,
  parameter int I_IMM_WIDTH           = 33,
  parameter int IM_MEM_ADDR_WIDTH     = 8,
  parameter int NUM_ID                = 6,
  parameter int NUM_IMM               = 3
) (
  input  logic                         iClk,
  input  logic                         iReset,
  cgra_im_loader_if.slave              dtl,
  output logic [NUM_ID+NUM_IMM-1:0]    oIM_WriteEnable,
  output logic [IM_MEM_ADDR_WIDTH-1:0] oIM_WriteAddress,
  output logic [I_WIDTH-1:0]           oIM_WriteData,
  output logic [I_IMM_WIDTH-1:0]       oIM_WriteData_IMM,
  output logic                         oConfigDone,
  output logic                         oProtocolError
);
  localparam int NUM_MEM = NUM_ID + NUM_IMM;
  localparam int WW      = IM_MEM_ADDR_WIDTH + 1;
  localparam int BW      = INTERFACE_BLOCK_WIDTH;
  localparam logic [3:0]         ID_LIM   = 4'(NUM_ID);
  localparam logic [3:0]         IMM_LIM  = 4'(NUM_MEM);
  localparam logic [3:0]         CTRL_SEL = 4'hF;
  localparam logic [NUM_MEM-1:0] MEM0     = NUM_MEM'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

  state_t                       state_q, state_d;
  logic [3:0]                   sel_q, sel_d;
  logic [WW-1:0]                word_q, word_d;
  logic [BW-1:0]                cnt_q, cnt_d;
  logic [31:0]                  hold_q, hold_d;
  logic [NUM_MEM-1:0]           we_q, we_d;
  logic [IM_MEM_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [I_WIDTH-1:0]           wdata_q, wdata_d;
  logic [I_IMM_WIDTH-1:0]       wdata_imm_q, wdata_imm_d;
  logic                         cfg_done_q, cfg_done_d;
  logic                         perr_q, perr_d;
  logic                         cmd_acc_q, cmd_acc_d;
  logic                         wr_acc_q, wr_acc_d;
  logic                         rd_vld_q, rd_vld_d;
  logic                         rd_last_q, rd_last_d;
  logic                         unused_addr_bits;

  assign unused_addr_bits = ^{dtl.iDTL_Loader_Address[INTERFACE_ADDR_WIDTH-1:IM_MEM_ADDR_WIDTH+7],
                              dtl.iDTL_Loader_Address[1:0]};

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    we_d        = '0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    wdata_imm_d = wdata_imm_q;
    cfg_done_d  = cfg_done_q;
    perr_d      = perr_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_acc_q && dtl.iDTL_Loader_CommandValid) begin
          sel_d   = dtl.iDTL_Loader_Address[IM_MEM_ADDR_WIDTH+6:IM_MEM_ADDR_WIDTH+3];
          word_d  = dtl.iDTL_Loader_Address[IM_MEM_ADDR_WIDTH+2:2];
          cnt_d   = dtl.iDTL_Loader_BlockSize;
          state_d = dtl.iDTL_Loader_CommandReadWrite ? ST_READ : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wr_acc_q && dtl.iDTL_Loader_WriteValid) begin
          // Only the word field advances, so the select stays fixed for the whole burst.
          word_d = word_q + WW'(1);
          if (dtl.iDTL_Loader_WriteLast != (cnt_q == '0)) perr_d = 1'b1;
          if (!(&dtl.iDTL_Loader_WriteEnable)) begin
            perr_d = 1'b1;
          end else if (sel_q < ID_LIM) begin
            we_d    = MEM0 << sel_q;
            waddr_d = word_q[IM_MEM_ADDR_WIDTH-1:0];
            wdata_d = dtl.iDTL_Loader_WriteData[I_WIDTH-1:0];
          end else if (sel_q < IMM_LIM) begin
            // Immediate words arrive low half first on the even word, high bits on the odd one.
            if (!word_q[0]) begin
              hold_d = dtl.iDTL_Loader_WriteData[31:0];
            end else begin
              we_d        = MEM0 << sel_q;
              waddr_d     = word_q[WW-1:1];
              wdata_imm_d = {dtl.iDTL_Loader_WriteData[I_IMM_WIDTH-33:0], hold_q};
            end
          end else if (sel_q == CTRL_SEL) begin
            cfg_done_d = dtl.iDTL_Loader_WriteData[0];
          end else begin
            perr_d = 1'b1;
          end
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - BW'(1);
        end
      end
      ST_READ: begin
        if (rd_vld_q && dtl.iDTL_Loader_ReadAccept) begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_acc_d = (state_d == ST_IDLE);
    wr_acc_d  = (state_d == ST_WRITE);
    rd_vld_d  = (state_d == ST_READ);
    rd_last_d = (state_d == ST_READ) && (cnt_d == '0);
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      word_q      <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      we_q        <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wdata_imm_q <= '0;
      cfg_done_q  <= 1'b0;
      perr_q      <= 1'b0;
      cmd_acc_q   <= 1'b0;
      wr_acc_q    <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      wdata_imm_q <= wdata_imm_d;
      cfg_done_q  <= cfg_done_d;
      perr_q      <= perr_d;
      cmd_acc_q   <= cmd_acc_d;
      wr_acc_q    <= wr_acc_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
    end
  end

  assign dtl.oDTL_Loader_CommandAccept = cmd_acc_q;
  assign dtl.oDTL_Loader_WriteAccept   = wr_acc_q;
  assign dtl.oDTL_Loader_ReadValid     = rd_vld_q;
  assign dtl.oDTL_Loader_ReadLast      = rd_last_q;
  assign dtl.oDTL_Loader_ReadData      = {{(INTERFACE_WIDTH-1){1'b0}}, cfg_done_q};

  assign oIM_WriteEnable   = we_q;
  assign oIM_WriteAddress  = waddr_q;
  assign oIM_WriteData     = wdata_q;
  assign oIM_WriteData_IMM = wdata_imm_q;
  assign oConfigDone       = cfg_done_q;
  assign oProtocolError    = perr_q;
endmodule

// File: tb/tb_cgra_im_loader.sv
// Directed bench for cgra_im_loader; addresses are built as (select << 11) | (word << 2).
module tb_cgra_im_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  im_we;
  logic [7:0]  im_addr;
  logic [11:0] im_data;
  logic [32:0] im_data_imm;
  logic        cfg_done;
  logic        perr;
  int          compared   = 0;
  int          mismatched = 0;

  cgra_im_loader_if #(.INTERFACE_WIDTH(32), .INTERFACE_ADDR_WIDTH(32), .INTERFACE_BLOCK_WIDTH(5)) dtl ();

  cgra_im_loader dut (
    .iClk              (clk),
    .iReset            (rst),
    .dtl               (dtl.slave),
    .oIM_WriteEnable   (im_we),
    .oIM_WriteAddress  (im_addr),
    .oIM_WriteData     (im_data),
    .oIM_WriteData_IMM (im_data_imm),
    .oConfigDone       (cfg_done),
    .oProtocolError    (perr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    compared++;
    mismatched++;
    $error("FAIL %s: observed no accept expected accept within 20 cycles", tag);
  endtask

  task automatic send_cmd(input logic rw, input logic [31:0] a, input logic [4:0] bs);
    int n = 0;
    dtl.iDTL_Loader_CommandValid     = 1'b1;
    dtl.iDTL_Loader_CommandReadWrite = rw;
    dtl.iDTL_Loader_Address          = a;
    dtl.iDTL_Loader_BlockSize        = bs;
    while (dtl.oDTL_Loader_CommandAccept !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) timeout_fail("cmd_accept");
    tick();
    dtl.iDTL_Loader_CommandValid = 1'b0;
  endtask

  task automatic write_beat(input logic [31:0] d, input logic [3:0] be, input logic last);
    int n = 0;
    dtl.iDTL_Loader_WriteValid  = 1'b1;
    dtl.iDTL_Loader_WriteData   = d;
    dtl.iDTL_Loader_WriteEnable = be;
    dtl.iDTL_Loader_WriteLast   = last;
    while (dtl.oDTL_Loader_WriteAccept !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) timeout_fail("write_accept");
    tick();
    dtl.iDTL_Loader_WriteValid = 1'b0;
    dtl.iDTL_Loader_WriteLast  = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    dtl.iDTL_Loader_CommandValid     = 1'b0;
    dtl.iDTL_Loader_CommandReadWrite = 1'b0;
    dtl.iDTL_Loader_Address          = '0;
    dtl.iDTL_Loader_BlockSize        = '0;
    dtl.iDTL_Loader_WriteValid       = 1'b0;
    dtl.iDTL_Loader_WriteEnable      = '0;
    dtl.iDTL_Loader_WriteData        = '0;
    dtl.iDTL_Loader_WriteLast        = 1'b0;
    dtl.iDTL_Loader_ReadAccept       = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_cmd_acc", dtl.oDTL_Loader_CommandAccept, 0);
    check("rst_wr_acc",  dtl.oDTL_Loader_WriteAccept, 0);
    check("rst_rd_vld",  dtl.oDTL_Loader_ReadValid, 0);
    check("rst_we",      im_we, 0);
    check("rst_perr",    perr, 0);
    check("rst_cfg",     cfg_done, 0);
    rst = 1'b0;
    tick();
    check("idle_cmd_acc", dtl.oDTL_Loader_CommandAccept, 1);

    // Single write to decoder memory 2, word 4
    send_cmd(1'b0, 32'h0000_1010, 5'd0);
    check("d2_wr_acc", dtl.oDTL_Loader_WriteAccept, 1);
    check("d2_cmd_acc_busy", dtl.oDTL_Loader_CommandAccept, 0);
    write_beat(32'h0000_0ABC, 4'hF, 1'b1);
    check("d2_we",      im_we, 9'b000000100);
    check("d2_addr",    im_addr, 8'd4);
    check("d2_data",    im_data, 12'hABC);
    check("d2_idle",    dtl.oDTL_Loader_CommandAccept, 1);
    tick();
    check("d2_we_pulse", im_we, 0);
    check("d2_addr_hold", im_addr, 8'd4);

    // Four-beat burst to decoder memory 0
    send_cmd(1'b0, 32'h0000_0000, 5'd3);
    for (int i = 0; i < 4; i++) begin
      write_beat(32'(i + 1), 4'hF, i == 3);
      check("b4_we",   im_we, 9'b000000001);
      check("b4_addr", im_addr, 64'(i));
      check("b4_data", im_data, 64'(i + 1));
    end
    check("b4_perr", perr, 0);

    // Immediate memory 6, words 2/3 -> instruction 1
    send_cmd(1'b0, 32'h0000_3008, 5'd1);
    write_beat(32'hDEAD_BEEF, 4'hF, 1'b0);
    check("imm_lo_no_we", im_we, 0);
    write_beat(32'h0000_0001, 4'hF, 1'b1);
    check("imm_we",   im_we, 9'b001000000);
    check("imm_addr", im_addr, 8'd1);
    check("imm_data", im_data_imm, 33'h1_DEAD_BEEF);
    check("imm_dec_data_hold", im_data, 12'h004);

    // Word address wraps 511 -> 0 without leaving decoder memory 0
    send_cmd(1'b0, 32'h0000_07FC, 5'd1);
    write_beat(32'h0000_0111, 4'hF, 1'b0);
    check("wrap_we0",   im_we, 9'b000000001);
    check("wrap_addr0", im_addr, 8'hFF);
    write_beat(32'h0000_0222, 4'hF, 1'b1);
    check("wrap_we1",   im_we, 9'b000000001);
    check("wrap_addr1", im_addr, 8'h00);
    check("wrap_data1", im_data, 12'h222);
    check("wrap_perr",  perr, 0);

    // Control register, then a throttled two-beat read
    send_cmd(1'b0, 32'h0000_7800, 5'd0);
    write_beat(32'h0000_0001, 4'hF, 1'b1);
    check("ctrl_no_we", im_we, 0);
    check("ctrl_cfg",   cfg_done, 1);
    send_cmd(1'b1, 32'h0000_7800, 5'd1);
    check("rd_vld0",  dtl.oDTL_Loader_ReadValid, 1);
    check("rd_data0", dtl.oDTL_Loader_ReadData, 1);
    check("rd_last0", dtl.oDTL_Loader_ReadLast, 0);
    check("rd_cmd_acc", dtl.oDTL_Loader_CommandAccept, 0);
    repeat (3) begin
      tick();
      check("rd_hold_vld",  dtl.oDTL_Loader_ReadValid, 1);
      check("rd_hold_last", dtl.oDTL_Loader_ReadLast, 0);
    end
    dtl.iDTL_Loader_ReadAccept = 1'b1;
    tick();
    check("rd_vld1",  dtl.oDTL_Loader_ReadValid, 1);
    check("rd_last1", dtl.oDTL_Loader_ReadLast, 1);
    check("rd_data1", dtl.oDTL_Loader_ReadData, 1);
    tick();
    dtl.iDTL_Loader_ReadAccept = 1'b0;
    check("rd_done_vld", dtl.oDTL_Loader_ReadValid, 0);
    check("rd_done_idle", dtl.oDTL_Loader_CommandAccept, 1);

    // Partial byte strobes: no write, sticky error
    send_cmd(1'b0, 32'h0000_0000, 5'd0);
    write_beat(32'h0000_0099, 4'h7, 1'b1);
    check("be_no_we", im_we, 0);
    check("be_perr",  perr, 1);
    repeat (3) tick();
    check("be_perr_sticky", perr, 1);
    pulse_reset();
    check("be_perr_cleared", perr, 0);
    check("be_cfg_cleared",  cfg_done, 0);

    // Early WriteLast: count still governs the burst
    send_cmd(1'b0, 32'h0000_0000, 5'd1);
    write_beat(32'h0000_0005, 4'hF, 1'b1);
    check("early_we",   im_we, 9'b000000001);
    check("early_perr", perr, 1);
    check("early_busy", dtl.oDTL_Loader_WriteAccept, 1);
    write_beat(32'h0000_0006, 4'hF, 1'b1);
    check("early_addr1", im_addr, 8'd1);
    check("early_idle",  dtl.oDTL_Loader_CommandAccept, 1);
    pulse_reset();

    // Unmapped select 10
    send_cmd(1'b0, 32'h0000_5000, 5'd0);
    write_beat(32'h0000_0007, 4'hF, 1'b1);
    check("unmap_no_we", im_we, 0);
    check("unmap_perr",  perr, 1);
    pulse_reset();

    // Reset during beat 2 of a 4-beat immediate burst drops the held low half
    send_cmd(1'b0, 32'h0000_3000, 5'd3);
    write_beat(32'h1234_5678, 4'hF, 1'b0);
    dtl.iDTL_Loader_WriteValid  = 1'b1;
    dtl.iDTL_Loader_WriteData   = 32'h0000_FFFF;
    dtl.iDTL_Loader_WriteEnable = 4'hF;
    rst = 1'b1;
    tick();
    check("mid_rst_cmd_acc", dtl.oDTL_Loader_CommandAccept, 0);
    check("mid_rst_wr_acc",  dtl.oDTL_Loader_WriteAccept, 0);
    check("mid_rst_we",      im_we, 0);
    check("mid_rst_addr",    im_addr, 0);
    check("mid_rst_data",    im_data, 0);
    check("mid_rst_imm",     im_data_imm, 0);
    rst = 1'b0;
    dtl.iDTL_Loader_WriteValid = 1'b0;
    tick();
    check("post_rst_cmd_acc", dtl.oDTL_Loader_CommandAccept, 1);
    send_cmd(1'b0, 32'h0000_3004, 5'd0);
    write_beat(32'h0000_0001, 4'hF, 1'b1);
    check("post_rst_imm_we",   im_we, 9'b001000000);
    check("post_rst_imm_addr", im_addr, 8'd0);
    check("post_rst_imm_data", im_data_imm, 33'h1_0000_0000);
    send_cmd(1'b0, 32'h0000_1010, 5'd0);
    write_beat(32'h0000_05A5, 4'hF, 1'b1);
    check("post_rst_we",   im_we, 9'b000000100);
    check("post_rst_data", im_data, 12'h5A5);
    check("post_rst_perr", perr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
